// File: rtl/slice_alu_pkg.sv
// rtl/slice_alu_pkg.sv - shared ALU control codes and FSM state encoding
package alu_pkg;

   localparam int CTRL_W = 4;

   localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_legal(input logic [CTRL_W-1:0] ctrl);
      case (ctrl)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: is_legal = 1'b1;
         default:                                              is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/slice_alu_if.sv
// rtl/slice_alu_if.sv - operand/result handshake bundle for slice_alu
interface slice_alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic              zero;
   logic              overflow;
   logic              carry_out;

   // master: the operand producer / result consumer around the ALU
   modport master (
      output in_valid, a, b, alu_ctrl, out_ready,
      input  in_ready, out_valid, result, zero, overflow, carry_out
   );

   modport slave (
      input  in_valid, a, b, alu_ctrl, out_ready,
      output in_ready, out_valid, result, zero, overflow, carry_out
   );
endinterface

// File: rtl/slice_alu_digit.sv
// rtl/slice_alu_digit.sv - combinational SLICE-bit digit: operand invert, logic ops, ripple adder
module alu_digit #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             a_invert,
   input  logic             b_invert,
   input  logic [1:0]       operation,
   input  logic             cin,
   output logic [SLICE-1:0] res,
   output logic             cout,
   output logic             c_msb,
   output logic             s_msb
);
   logic [SLICE-1:0] ai;
   logic [SLICE-1:0] bi;
   logic [SLICE-1:0] sum;

   assign ai = a ^ {SLICE{a_invert}};
   assign bi = b ^ {SLICE{b_invert}};

   always_comb begin
      logic cc;
      cc    = cin;
      c_msb = 1'b0;
      sum   = '0;
      for (int i = 0; i < SLICE; i++) begin
         sum[i] = ai[i] ^ bi[i] ^ cc;
         if (i == SLICE - 1) c_msb = cc;
         cc = (ai[i] & bi[i]) | ((ai[i] ^ bi[i]) & cc);
      end
      cout = cc;
   end

   assign s_msb = sum[SLICE-1];

   // SLT digits stay zero; the top inserts the comparison bit on the last digit
   always_comb begin
      case (operation)
         2'b00:   res = ai & bi;
         2'b01:   res = ai | bi;
         2'b10:   res = sum;
         default: res = '0;
      endcase
   end
endmodule

// File: rtl/slice_alu.sv
// rtl/slice_alu.sv - digit-serial ALU top (FSM, counter, regs); SLICE_ALU_SLT_OVF_FIX_EN selects signed-correct SLT
module slice_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input logic        clk,
   input logic        rst_n,
   slice_alu_if.slave bus
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   state_t            state;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [CTRL_W-1:0] ctrl_r;
   logic [CNT_W-1:0]  cnt;
   logic              carry;
   logic [WIDTH-1:0]  res_r;
   logic              zero_r;
   logic              ovf_r;
   logic              cout_r;
   logic              in_ready_r;
   logic              out_valid_r;

   logic [31:0]       base;
   logic [SLICE-1:0]  d_res;
   logic [SLICE-1:0]  d_res_m;
   logic              d_cout;
   logic              d_cmsb;
   logic              d_smsb;
   logic [WIDTH-1:0]  res_fin;
   logic              ovf_raw;
   logic              less;
   logic              arith;

   assign base = 32'(cnt) * 32'(SLICE);

   alu_digit #(.SLICE(SLICE)) u_digit (
      .a         (a_r[base +: SLICE]),
      .b         (b_r[base +: SLICE]),
      .a_invert  (ctrl_r[3]),
      .b_invert  (ctrl_r[2]),
      .operation (ctrl_r[1:0]),
      .cin       (carry),
      .res       (d_res),
      .cout      (d_cout),
      .c_msb     (d_cmsb),
      .s_msb     (d_smsb)
   );

   assign d_res_m = is_legal(ctrl_r) ? d_res : '0;
   assign arith   = (ctrl_r == ALU_ADD) || (ctrl_r == ALU_SUB);
   assign ovf_raw = d_cmsb ^ d_cout;

   // Only meaningful while the MSB digit is in the adder (cnt == LAST)
   always_comb begin
`ifdef SLICE_ALU_SLT_OVF_FIX_EN
      less = d_smsb ^ ovf_raw;
`else
      less = d_smsb;
`endif
      res_fin = res_r;
      res_fin[base +: SLICE] = d_res_m;
      if (ctrl_r == ALU_SLT) res_fin = {{(WIDTH-1){1'b0}}, less};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         a_r         <= '0;
         b_r         <= '0;
         ctrl_r      <= '0;
         cnt         <= '0;
         carry       <= 1'b0;
         res_r       <= '0;
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
         cout_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  ctrl_r     <= bus.alu_ctrl;
                  cnt        <= '0;
                  carry      <= bus.alu_ctrl[2];
                  res_r      <= '0;
                  zero_r     <= 1'b0;
                  ovf_r      <= 1'b0;
                  cout_r     <= 1'b0;
                  in_ready_r <= 1'b0;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               carry <= d_cout;
               if (cnt == LAST) begin
                  res_r       <= res_fin;
                  zero_r      <= (res_fin == '0);
                  ovf_r       <= arith & ovf_raw;
                  cout_r      <= arith & d_cout;
                  out_valid_r <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  res_r[base +: SLICE] <= d_res_m;
                  cnt                  <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = res_r;
   assign bus.zero      = zero_r;
   assign bus.overflow  = ovf_r;
   assign bus.carry_out = cout_r;
endmodule

// File: tb/tb_slice_alu.sv
// tb/tb_slice_alu.sv - directed self-checking bench for slice_alu (32/8 and 8/8 instances)
module tb_slice_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   fails = 0;
   int   lat;
   logic [31:0] slt_ovf_exp;

   always #5 clk = ~clk;

   slice_alu_if #(.WIDTH(32)) bus32 ();
   slice_alu_if #(.WIDTH(8))  bus8 ();

   slice_alu #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
   slice_alu #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op on the 32-bit DUT; lat = edges from accept edge to out_valid
   task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                       output int l);
      int k;
      k = 0;
      while (!bus32.in_ready && k < 20) begin
         @(posedge clk); #1; k++;
      end
      bus32.a = a; bus32.b = b; bus32.alu_ctrl = ctrl; bus32.in_valid = 1'b1;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      bus32.a = ~a; bus32.b = ~b; bus32.alu_ctrl = 4'b1111;
      l = 0;
      while (!bus32.out_valid && l < 20) begin
         @(posedge clk); #1; l++;
      end
   endtask

   task automatic res32(input string tag, input logic [31:0] r, input logic z,
                        input logic o, input logic c);
      chk({tag, "_result"}, bus32.result, r);
      chk({tag, "_zero"},   32'(bus32.zero), 32'(z));
      chk({tag, "_ovf"},    32'(bus32.overflow), 32'(o));
      chk({tag, "_cout"},   32'(bus32.carry_out), 32'(c));
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
`ifdef SLICE_ALU_SLT_OVF_FIX_EN
      slt_ovf_exp = 32'd1;
`else
      slt_ovf_exp = 32'd0;
`endif
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.alu_ctrl = '0; bus32.out_ready = 1'b0;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.alu_ctrl  = '0; bus8.out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus32.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus32.out_valid), 32'd0);
      chk("rst_result",    bus32.result, 32'd0);
      chk("rst_flags",     {29'd0, bus32.zero, bus32.overflow, bus32.carry_out}, 32'd0);
      chk("rst8_in_ready", 32'(bus8.in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op32(32'h7FFFFFFF, 32'h00000001, ALU_ADD, lat);
      chk("add_ovf_latency", 32'(lat), 32'd4);
      res32("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);

      op32(32'd5, 32'd5, ALU_SUB, lat);
      res32("sub_eq", 32'h0, 1'b1, 1'b0, 1'b1);

      op32(32'h80000000, 32'd1, ALU_SLT, lat);
      res32("slt_ovf", slt_ovf_exp, (slt_ovf_exp == 32'd0), 1'b0, 1'b0);

      op32(32'd3, 32'd7, ALU_SLT, lat);
      res32("slt_3_7", 32'd1, 1'b0, 1'b0, 1'b0);

      op32(32'd0, 32'd0, ALU_NOR, lat);
      res32("nor_0_0", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

      op32(32'h00001234, 32'h000000FF, 4'b0101, lat);
      chk("illegal_latency", 32'(lat), 32'd4);
      res32("illegal", 32'h0, 1'b1, 1'b0, 1'b0);

      op32(32'hF0F0F0F0, 32'hFF00FF00, ALU_AND, lat);
      res32("and", 32'hF000F000, 1'b0, 1'b0, 1'b0);

      op32(32'hF0F0F0F0, 32'hFF00FF00, ALU_OR, lat);
      res32("or", 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);

      op32(32'h000000FF, 32'h00000001, ALU_ADD, lat);
      res32("add_digit_carry", 32'h00000100, 1'b0, 1'b0, 1'b0);

      op32(32'hFFFFFFFF, 32'h00000001, ALU_ADD, lat);
      res32("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1);

      op32(32'd1, 32'd2, ALU_ADD, lat);
      bus32.in_valid = 1'b1; bus32.a = 32'h11111111; bus32.b = 32'h22222222; bus32.alu_ctrl = ALU_SUB;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_result",    bus32.result, 32'd3);
         chk("bp_out_valid", 32'(bus32.out_valid), 32'd1);
         chk("bp_in_ready",  32'(bus32.in_ready), 32'd0);
      end
      bus32.in_valid = 1'b0;
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
      chk("bp_pop_out_valid", 32'(bus32.out_valid), 32'd0);
      chk("bp_pop_in_ready",  32'(bus32.in_ready), 32'd1);

      bus32.a = 32'd9; bus32.b = 32'd4; bus32.alu_ctrl = ALU_SUB; bus32.in_valid = 1'b1;
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_run_partial", bus32.result, 32'd5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready",  32'(bus32.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus32.out_valid), 32'd0);
      chk("mid_rst_result",    bus32.result, 32'd0);
      chk("mid_rst_flags",     {29'd0, bus32.zero, bus32.overflow, bus32.carry_out}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_no_valid", 32'(bus32.out_valid), 32'd0);
      op32(32'd9, 32'd4, ALU_SUB, lat);
      chk("post_rst_latency", 32'(lat), 32'd4);
      res32("post_rst_sub", 32'd5, 1'b0, 1'b0, 1'b1);

      bus8.a = 8'hFF; bus8.b = 8'h01; bus8.alu_ctrl = ALU_ADD; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      chk("w8_in_ready_busy", 32'(bus8.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("w8_out_valid", 32'(bus8.out_valid), 32'd1);
      chk("w8_result",    32'(bus8.result), 32'd0);
      chk("w8_cout",      32'(bus8.carry_out), 32'd1);
      chk("w8_zero",      32'(bus8.zero), 32'd1);
      chk("w8_ovf",       32'(bus8.overflow), 32'd0);
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      chk("w8_pop", 32'(bus8.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
